char_writer: RTL and testbench

Write-side companion to the character display. It turns a byte stream (ASCII plus a few control codes) into writes to the 64×16 character RAM, keeping its own cursor, line wrap and screen/line clearing. It drives the RAM write port (`ram_Adr`, `ram_Data`, `write_Ram`) that the display reads on the opposite clock edge. The address format is `{row[3:0], col[5:0]}`.

---
 rtl/char_writer_pkg.sv | 27 ++
 rtl/char_writer_if.sv | 23 ++
 rtl/char_clear_seq.sv | 41 ++++
 rtl/char_writer.sv | 199 +++++++++++++++++++
 tb/tb_char_writer.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/char_writer_pkg.sv
// Shared display definitions: control codes, state encoding,
// physical screen geometry and the {row,col} address packer.
package char_writer_pkg;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] BS = 8'h08;
  localparam logic [7:0] FF = 8'h0C;

  localparam int SCREEN_COLS_PHYS = 64;
  localparam int SCREEN_ROWS_PHYS = 16;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    CLRLINE,
    CLRALL
  } state_t;

  function automatic logic [9:0] pack_adr(
    input logic [3:0] row,
    input logic [5:0] col
  );
    return {row, col};
  endfunction

endpackage

// File: rtl/char_writer_if.sv
// Byte-stream handshake plus character-RAM write port.
// master: byte source / RAM side; slave: char_writer.
interface char_writer_if;
  import char_writer_pkg::*;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] ram_Adr;
  logic [7:0] ram_Data;
  logic       write_Ram;

  modport master (
    output in_data, in_valid,
    input  in_ready, ram_Adr, ram_Data, write_Ram
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ram_Adr, ram_Data, write_Ram
  );

endinterface

// File: rtl/char_clear_seq.sv
// Address sweeper for line/screen clears: loads base+length on
// i_start, advances on i_step, flags the last cell with o_done.
import char_writer_pkg::*;

module char_clear_seq (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_start,
  input  logic [9:0] i_base,
  input  logic [9:0] i_len_m1,
  input  logic       i_step,
  output logic [9:0] o_next_adr,
  output logic       o_done
);

  localparam logic [9:0] FULL_M1 =
    10'(SCREEN_COLS_PHYS * SCREEN_ROWS_PHYS - 1);

  logic [9:0] r_base;
  logic [9:0] r_cnt;
  logic [9:0] r_last;

  // Reset value matches the post-reset full-screen sweep.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base <= '0;
      r_cnt  <= '0;
      r_last <= FULL_M1;
    end else if (i_start) begin
      r_base <= i_base;
      r_cnt  <= '0;
      r_last <= i_len_m1;
    end else if (i_step) begin
      r_cnt <= r_cnt + 10'd1;
    end
  end

  assign o_next_adr = r_base + r_cnt + 10'd1;
  assign o_done     = (r_cnt == r_last);

endmodule

// File: rtl/char_writer.sv
// Byte stream to 64x16 character RAM writer with cursor, wrap,
// backspace and line/screen clear. All outputs registered.
import char_writer_pkg::*;

module char_writer #(
  parameter int         COLS           = 48,
  parameter int         ROWS           = 16,
  parameter logic [7:0] FILL           = 8'h20,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  char_writer_if.slave     bus,
  output logic [5:0]       cursor_col,
  output logic [3:0]       cursor_row,
  output logic             busy
);

  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
  localparam logic [9:0] LINE_M1  = 10'(SCREEN_COLS_PHYS - 1);
  localparam logic [9:0] FULL_M1  =
    10'(SCREEN_COLS_PHYS * SCREEN_ROWS_PHYS - 1);

  state_t     r_state;
  logic       r_rdy;
  logic       r_busy;
  logic       r_we;
  logic       r_bs;
  logic [9:0] r_adr;
  logic [7:0] r_data;
  logic [5:0] r_col;
  logic [3:0] r_row;

  logic [7:0] w_d;
  logic       w_xfer;
  logic       w_print;
  logic       w_cr;
  logic       w_lf;
  logic       w_bs;
  logic       w_ff;
  logic [3:0] w_row_inc;
  logic       w_wrap;
  logic       w_start_line;
  logic       w_start_all;
  logic [9:0] w_base;
  logic [9:0] w_len_m1;
  logic       w_clr;
  logic       w_step;
  logic [9:0] w_next;
  logic       w_done;

  assign w_d     = bus.in_data;
  assign w_xfer  = bus.in_valid && r_rdy;
  assign w_print = (w_d >= 8'h20) && (w_d != 8'h7F);
  assign w_cr    = (w_d == CR);
  assign w_lf    = (w_d == LF);
  assign w_bs    = (w_d == BS) && (r_col != 6'd0);
  assign w_ff    = (w_d == FF);

  assign w_row_inc = (r_row == LAST_ROW) ? 4'd0 : r_row + 4'd1;

  assign w_wrap = (r_state == WRITE) && !r_bs &&
                  (r_col == LAST_COL);

  assign w_start_line = (w_xfer && w_lf) || w_wrap;
  assign w_start_all  = w_xfer && w_ff;
  assign w_base   = w_start_line ? pack_adr(w_row_inc, 6'd0)
                                 : 10'd0;
  assign w_len_m1 = w_start_all ? FULL_M1 : LINE_M1;

  assign w_clr  = (r_state == CLRLINE) || (r_state == CLRALL);
  assign w_step = w_clr && r_we && !w_done;

  char_clear_seq u_seq (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_start    (w_start_line || w_start_all),
    .i_base     (w_base),
    .i_len_m1   (w_len_m1),
    .i_step     (w_step),
    .o_next_adr (w_next),
    .o_done     (w_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= CLEAR_ON_RESET ? CLRALL : IDLE;
      r_rdy   <= 1'b0;
      r_busy  <= 1'b0;
      r_we    <= 1'b0;
      r_bs    <= 1'b0;
      r_adr   <= '0;
      r_data  <= '0;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_we   <= 1'b0;
          r_rdy  <= 1'b1;
          r_busy <= 1'b0;
          if (w_xfer) begin
            unique case (1'b1)
              w_print: begin
                r_state <= WRITE;
                r_adr   <= pack_adr(r_row, r_col);
                r_data  <= w_d;
                r_bs    <= 1'b0;
                r_we    <= 1'b1;
                r_rdy   <= 1'b0;
                r_busy  <= 1'b1;
              end
              w_bs: begin
                r_state <= WRITE;
                r_adr   <= pack_adr(r_row, r_col - 6'd1);
                r_data  <= FILL;
                r_bs    <= 1'b1;
                r_we    <= 1'b1;
                r_rdy   <= 1'b0;
                r_busy  <= 1'b1;
              end
              w_cr: r_col <= '0;
              w_lf: begin
                r_state <= CLRLINE;
                r_row   <= w_row_inc;
                r_col   <= '0;
                r_adr   <= w_base;
                r_data  <= FILL;
                r_we    <= 1'b1;
                r_rdy   <= 1'b0;
                r_busy  <= 1'b1;
              end
              w_ff: begin
                r_state <= CLRALL;
                r_row   <= '0;
                r_col   <= '0;
                r_adr   <= '0;
                r_data  <= FILL;
                r_we    <= 1'b1;
                r_rdy   <= 1'b0;
                r_busy  <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        WRITE: begin
          r_state <= IDLE;
          r_we    <= 1'b0;
          r_rdy   <= 1'b1;
          r_busy  <= 1'b0;
          if (r_bs) begin
            r_col <= r_col - 6'd1;
          end else if (w_wrap) begin
            r_state <= CLRLINE;
            r_col   <= '0;
            r_row   <= w_row_inc;
            r_adr   <= w_base;
            r_data  <= FILL;
            r_we    <= 1'b1;
            r_rdy   <= 1'b0;
            r_busy  <= 1'b1;
          end else begin
            r_col <= r_col + 6'd1;
          end
        end
        CLRLINE, CLRALL: begin
          r_data <= FILL;
          r_we   <= 1'b1;
          r_rdy  <= 1'b0;
          r_busy <= 1'b1;
          // r_we low only on the first cycle after reset:
          // address 0 is already loaded, just start strobing.
          if (r_we) begin
            if (w_done) begin
              r_state <= IDLE;
              r_we    <= 1'b0;
              r_rdy   <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_adr <= w_next;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_rdy;
  assign bus.ram_Adr   = r_adr;
  assign bus.ram_Data  = r_data;
  assign bus.write_Ram = r_we;
  assign cursor_col    = r_col;
  assign cursor_row    = r_row;
  assign busy          = r_busy;

endmodule

// File: tb/tb_char_writer.sv
// Randomised self-checking bench for char_writer against a
// cursor/write-list reference model.
module tb_char_writer;

  localparam int COLS = 48;
  localparam int ROWS = 16;
  localparam logic [7:0] FILLB = 8'h20;

  typedef logic [17:0] wr_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] cursor_col;
  logic [3:0] cursor_row;
  logic       busy;

  char_writer_if bus();

  char_writer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  wr_t obs[$];
  wr_t exp_q[$];
  int  obs_cyc[$];
  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  int  mr = 0;
  int  mc = 0;
  int  d;

  always @(posedge clk) cyc++;

  always @(negedge clk)
    if (reset_n && bus.write_Ram) begin
      obs.push_back({bus.ram_Adr, bus.ram_Data});
      obs_cyc.push_back(cyc);
    end

  task automatic push_exp(input int a, input logic [7:0] v);
    exp_q.push_back({10'(a), v});
  endtask

  task automatic clr_line(input int r);
    for (int c = 0; c < 64; c++) push_exp(r * 64 + c, FILLB);
  endtask

  // Reference: what the screen writer must do for one byte.
  task automatic model_byte(input logic [7:0] b);
    if (b == 8'h0D) mc = 0;
    else if (b == 8'h0A) begin
      mr = (mr + 1) % ROWS; mc = 0; clr_line(mr);
    end else if (b == 8'h08) begin
      if (mc > 0) begin mc--; push_exp(mr * 64 + mc, FILLB); end
    end else if (b == 8'h0C) begin
      mr = 0; mc = 0;
      for (int i = 0; i < 1024; i++) push_exp(i, FILLB);
    end else if (b < 8'h20 || b == 8'h7F) begin
    end else begin
      push_exp(mr * 64 + mc, b);
      mc++;
      if (mc == COLS) begin
        mc = 0; mr = (mr + 1) % ROWS; clr_line(mr);
      end
    end
  endtask

  function automatic int first_diff();
    int n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (obs[i] !== exp_q[i]) return i;
    if (obs.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic clear_logs();
    obs.delete(); exp_q.delete(); obs_cyc.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 3000) begin
      @(negedge clk); t++;
    end
    if (!bus.in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout in_ready got 0 want 1");
    end else begin
      bus.in_data = b;
      bus.in_valid = 1'b1;
      model_byte(b);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (!(bus.in_ready && !busy) && t < 3000) begin
      @(negedge clk); t++;
    end
    if (!(bus.in_ready && !busy)) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout ready/busy got %b%b want 10",
               bus.in_ready, busy);
    end
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.in_ready, bus.write_Ram, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctl got %b want 000",
               {bus.in_ready, bus.write_Ram, busy});
    end
    n_tests++;
    if ({cursor_row, cursor_col, bus.ram_Adr, bus.ram_Data}
        !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_out got %h want 0",
               {cursor_row, cursor_col, bus.ram_Adr, bus.ram_Data});
    end
    clear_logs();
    mr = 0; mc = 0;
    for (int i = 0; i < 1024; i++) push_exp(i, FILLB);
    reset_n = 1'b1;
    wait_idle();
    d = first_diff();
    n_tests++;
    if (d !== -1) begin
      n_fail++;
      $display("FAIL reset_clear idx %0d got %h want %h (n %0d/%0d)",
               d, obs[d], exp_q[d], obs.size(), exp_q.size());
    end
    n_tests++;
    if ({cursor_row, cursor_col} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_cursor got %h want 0",
               {cursor_row, cursor_col});
    end
  endtask

  task automatic test_ab();
    clear_logs();
    send_byte(8'h41);
    send_byte(8'h42);
    wait_idle();
    d = first_diff();
    n_tests++;
    if (d !== -1) begin
      n_fail++;
      $display("FAIL ab_writes idx %0d got %h want %h",
               d, obs[d], exp_q[d]);
    end
    n_tests++;
    if (obs_cyc.size() != 2 || obs_cyc[1] - obs_cyc[0] != 2) begin
      n_fail++;
      $display("FAIL ab_spacing got %0d writes want 2 spaced by 2",
               obs_cyc.size());
    end
    n_tests++;
    if ({cursor_row, cursor_col} !== {4'd0, 6'd2}) begin
      n_fail++;
      $display("FAIL ab_cursor got %0d,%0d want 0,2",
               cursor_row, cursor_col);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] b;
    send_byte(8'h0C);
    wait_idle();
    clear_logs();
    for (int i = 0; i < COLS; i++) begin
      b = 8'($urandom_range(8'h21, 8'h7E));
      send_byte(b);
    end
    wait_idle();
    d = first_diff();
    n_tests++;
    if (d !== -1) begin
      n_fail++;
      $display("FAIL wrap_writes idx %0d got %h want %h (n %0d/%0d)",
               d, obs[d], exp_q[d], obs.size(), exp_q.size());
    end
    n_tests++;
    if (obs.size() < 49 || obs[47][17:8] !== 10'h02F
        || obs[48][17:8] !== 10'h040) begin
      n_fail++;
      $display("FAIL wrap_edge got %0d writes want 112, 48th at 02f",
               obs.size());
    end
    n_tests++;
    if ({cursor_row, cursor_col} !== {4'd1, 6'd0}) begin
      n_fail++;
      $display("FAIL wrap_cursor got %0d,%0d want 1,0",
               cursor_row, cursor_col);
    end
  endtask

  task automatic test_lf_last_row();
    send_byte(8'h0C);
    for (int i = 0; i < 15; i++) send_byte(8'h0A);
    for (int i = 0; i < 5; i++) send_byte(8'h61);
    wait_idle();
    clear_logs();
    send_byte(8'h0A);
    wait_idle();
    d = first_diff();
    n_tests++;
    if (d !== -1 || obs.size() != 64) begin
      n_fail++;
      $display("FAIL lf_wrap idx %0d got n %0d want 64 at 000..03f",
               d, obs.size());
    end
    n_tests++;
    if ({cursor_row, cursor_col} !== 10'd0) begin
      n_fail++;
      $display("FAIL lf_cursor got %0d,%0d want 0,0",
               cursor_row, cursor_col);
    end
  endtask

  task automatic test_bs();
    send_byte(8'h0C);
    send_byte(8'h0A);
    send_byte(8'h0A);
    for (int i = 0; i < 3; i++) send_byte(8'h5A);
    wait_idle();
    clear_logs();
    send_byte(8'h08);
    wait_idle();
    n_tests++;
    if (obs.size() != 1 || obs[0] !== {10'h082, 8'h20}) begin
      n_fail++;
      $display("FAIL bs_write got n %0d want one 082:20",
               obs.size());
    end
    n_tests++;
    if ({cursor_row, cursor_col} !== {4'd2, 6'd2}) begin
      n_fail++;
      $display("FAIL bs_cursor got %0d,%0d want 2,2",
               cursor_row, cursor_col);
    end
    send_byte(8'h0D);
    clear_logs();
    send_byte(8'h08);
    wait_idle();
    n_tests++;
    if (obs.size() != 0
        || {cursor_row, cursor_col} !== {4'd2, 6'd0}) begin
      n_fail++;
      $display("FAIL bs_col0 got n %0d at %0d,%0d want 0 at 2,0",
               obs.size(), cursor_row, cursor_col);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic [7:0] ign [5];
    int k;
    ign = '{8'h00, 8'h07, 8'h1B, 8'h7F, 8'h09};
    clear_logs();
    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 99);
      if (k < 60) begin
        b = 8'($urandom_range(8'h20, 8'hFF));
        if (b == 8'h7F) b = 8'h41;
      end else if (k < 70) b = 8'h0D;
      else if (k < 78) b = 8'h0A;
      else if (k < 88) b = 8'h08;
      else if (k < 97) b = ign[$urandom_range(0, 4)];
      else b = 8'h0C;
      send_byte(b);
    end
    wait_idle();
    d = first_diff();
    n_tests++;
    if (d !== -1) begin
      n_fail++;
      $display("FAIL rand_writes idx %0d got %h want %h (n %0d/%0d)",
               d, obs[d], exp_q[d], obs.size(), exp_q.size());
    end
    n_tests++;
    if ({cursor_row, cursor_col} !== {4'(mr), 6'(mc)}) begin
      n_fail++;
      $display("FAIL rand_cursor got %0d,%0d want %0d,%0d",
               cursor_row, cursor_col, mr, mc);
    end
  endtask

  task automatic test_reset_mid_clear();
    int t = 0;
    send_byte(8'h0C);
    @(negedge clk);
    while (!(bus.write_Ram && bus.ram_Adr == 10'd500) && t < 2000)
    begin
      @(negedge clk); t++;
    end
    n_tests++;
    if (bus.ram_Adr !== 10'd500) begin
      n_fail++;
      $display("FAIL mid_reach got %h want 1f4", bus.ram_Adr);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.write_Ram, bus.in_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_abort we/rdy got %b want 00",
               {bus.write_Ram, bus.in_ready});
    end
    clear_logs();
    mr = 0; mc = 0;
    for (int i = 0; i < 1024; i++) push_exp(i, FILLB);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_idle();
    d = first_diff();
    n_tests++;
    if (d !== -1) begin
      n_fail++;
      $display("FAIL mid_fresh idx %0d got %h want %h (n %0d/%0d)",
               d, obs[d], exp_q[d], obs.size(), exp_q.size());
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    test_reset();
    test_ab();
    test_wrap();
    test_lf_last_row();
    test_bs();
    test_random();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
